// File: rtl/demux_2_select_buf.sv
// demux_2_select_buf
// Routes one valid/ready input stream to one of four output channels picked by
// a 2-bit select. Each channel owns a one-entry holding register, so a stalled
// consumer only blocks words headed for its own channel. Enable is active-low.
// A free-running counter records how many input words were accepted.

module demux_2_select_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_select,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic [DATA_WIDTH-1:0] out_data3,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    // Per-channel holding registers and their full flags
    logic [3:0]            valid_q;
    logic [DATA_WIDTH-1:0] data_q [4];
    logic [CNT_WIDTH-1:0]  count_q;

    // Handshake decode
    logic       sel_free;
    logic       accept;
    logic [3:0] push;
    logic [3:0] pop;

    // Accept only when the selected channel is empty or being drained this
    // cycle; the fullness of unselected channels never gates the input
    always_comb begin
        sel_free = 1'b0;
        in_ready = 1'b0;
        accept   = 1'b0;
        push     = 4'b0000;
        pop      = valid_q & out_ready;

        sel_free = ~valid_q[in_select] | out_ready[in_select];
        in_ready = rst_n & ~enable & sel_free;
        accept   = in_valid & in_ready;
        if (accept) begin
            push[in_select] = 1'b1;
        end
    end

    // Channel full flags: a push wins over a pop so a simultaneous pop and
    // push leaves the channel full with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    valid_q[i] <= 1'b1;
                end else if (pop[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Channel data: loaded only on a push, otherwise keeps its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    // Accepted-transfer counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign out_valid  = valid_q;
    assign out_data0  = data_q[0];
    assign out_data1  = data_q[1];
    assign out_data2  = data_q[2];
    assign out_data3  = data_q[3];
    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux_2_select_buf.sv
// Testbench for demux_2_select_buf: scenario tasks plus a randomized run,
// all checked against a channel-level reference model.

module tb_demux_2_select_buf;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_select;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] xfer_count;

    // Second instance with a narrow counter to observe wrap-around
    logic        w_in_ready;
    logic [31:0] w_data0, w_data1, w_data2, w_data3;
    logic [3:0]  w_valid;
    logic [3:0]  w_count;

    int checks;
    int errors;

    // Reference model: per-channel full flag, word, and total accept count
    logic [3:0]  m_valid;
    logic [31:0] m_data [4];
    logic [31:0] m_count;

    demux_2_select_buf #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
        .in_valid(in_valid), .in_ready(in_ready), .enable(enable),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_count(xfer_count)
    );

    demux_2_select_buf #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
        .in_valid(in_valid), .in_ready(w_in_ready), .enable(enable),
        .out_data0(w_data0), .out_data1(w_data1), .out_data2(w_data2),
        .out_data3(w_data3), .out_valid(w_valid), .out_ready(out_ready),
        .xfer_count(w_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_ready();
        return rst_n && !enable && (!m_valid[in_select] || out_ready[in_select]);
    endfunction

    function automatic logic [127:0] model_data();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    function automatic logic [15:0] model_count16();
        logic [31:0] c;
        c = m_count;
        return c[15:0];
    endfunction

    function automatic logic [3:0] model_count4();
        logic [31:0] c;
        c = m_count;
        return c[3:0];
    endfunction

    task automatic model_clear();
        m_valid = 4'b0000;
        for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
        m_count = 32'h0;
    endtask

    // Advance one clock: decide the transfer from current inputs, then update
    // the model after the edge; returns 1 ns after the rising edge
    task automatic tick();
        logic        acc;
        logic [3:0]  nv;
        logic [1:0]  sel;
        logic [31:0] d;
        acc = in_valid && model_ready();
        sel = in_select;
        d   = in_data;
        nv  = m_valid & ~out_ready;
        @(posedge clk);
        #1;
        m_valid = nv;
        if (acc) begin
            m_valid[sel] = 1'b1;
            m_data[sel]  = d;
            m_count      = m_count + 1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        enable    = 1'b0;
        out_ready = 4'b0000;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 4'b0000 || xfer_count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: valid %b count %0d expected 0000 and 0", out_valid, xfer_count);
        end
        checks++;
        if ({out_data3, out_data2, out_data1, out_data0} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {out_data3, out_data2, out_data1, out_data0});
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_single_route();
        do_reset();
        in_select = 2'd2;
        in_data   = 32'hDEADBEEF;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL route_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100 || out_valid !== m_valid) begin
            errors++;
            $display("[TB] FAIL route_valid: got %b expected 0100", out_valid);
        end
        checks++;
        if ({out_data3, out_data2, out_data1, out_data0} !== {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL route_data: got %h expected %h", {out_data3, out_data2, out_data1, out_data0}, model_data());
        end
        checks++;
        if (xfer_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL route_count: got %0d expected 1", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        do_reset();
        a = $urandom;
        b = ~a;
        in_select = 2'd1;
        in_data   = a;
        in_valid  = 1'b1;
        tick();
        in_data = b;
        #1;
        checks++;
        if (in_ready !== 1'b0 || in_ready !== model_ready()) begin
            errors++;
            $display("[TB] FAIL bp_stall_ready: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_data1 !== a || out_valid !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_hold: data %h valid %b expected %h 0010", out_data1, out_valid, a);
        end
        out_ready = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_refill_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (out_data1 !== b || out_valid !== 4'b0010 || out_data1 !== m_data[1]) begin
            errors++;
            $display("[TB] FAIL bp_refill: data %h valid %b expected %h 0010", out_data1, out_valid, b);
        end
        checks++;
        if (xfer_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d expected 2", xfer_count);
        end
    endtask

    task automatic test_independent();
        logic [15:0] start;
        do_reset();
        in_valid  = 1'b1;
        in_select = 2'd0;
        in_data   = $urandom;
        tick();
        start = xfer_count;
        for (int ch = 1; ch < 4; ch++) begin
            in_select = 2'(ch);
            in_data   = $urandom;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL indep_ready ch%0d: got %b expected 1", ch, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL indep_valid: got %b expected 1111", out_valid);
        end
        checks++;
        if ({out_data3, out_data2, out_data1, out_data0} !== model_data()) begin
            errors++;
            $display("[TB] FAIL indep_data: got %h expected %h", {out_data3, out_data2, out_data1, out_data0}, model_data());
        end
        checks++;
        if (xfer_count !== start + 16'd3) begin
            errors++;
            $display("[TB] FAIL indep_count: got %0d expected %0d", xfer_count, start + 16'd3);
        end
    endtask

    // Continues from the all-full state left by test_independent
    task automatic test_enable_high();
        logic [15:0] start;
        start     = xfer_count;
        enable    = 1'b1;
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_select = 2'd3;
        in_data   = $urandom;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_ready cycle%0d: got %b expected 0", k, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        enable    = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (out_valid !== 4'b1110 || out_valid !== m_valid) begin
            errors++;
            $display("[TB] FAIL en_drain: got %b expected 1110", out_valid);
        end
        checks++;
        if (xfer_count !== start) begin
            errors++;
            $display("[TB] FAIL en_count: got %0d expected %0d", xfer_count, start);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_select = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (w_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL wrap_count4: got %0d expected 1", w_count);
        end
        checks++;
        if (xfer_count !== 16'd17) begin
            errors++;
            $display("[TB] FAIL wrap_count16: got %0d expected 17", xfer_count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_select = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            enable    = ($urandom_range(0, 7) == 0);
            out_ready = 4'($urandom);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready step%0d: got %b expected %b", k, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || {out_data3, out_data2, out_data1, out_data0} !== model_data()) begin
                errors++;
                $display("[TB] FAIL rand_out step%0d: valid %b data %h expected %b %h", k, out_valid, {out_data3, out_data2, out_data1, out_data0}, m_valid, model_data());
            end
            checks++;
            if (xfer_count !== model_count16() || w_count !== model_count4()) begin
                errors++;
                $display("[TB] FAIL rand_count step%0d: got %0d/%0d expected %0d/%0d", k, xfer_count, w_count, model_count16(), model_count4());
            end
        end
        in_valid  = 1'b0;
        enable    = 1'b0;
        out_ready = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            if (ch != 2) begin
                in_select = 2'(ch);
                in_data   = $urandom | 32'h1;
                tick();
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL arst_setup: got %b expected 1011", out_valid);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (out_valid !== 4'b0000 || xfer_count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL arst_state: valid %b count %0d expected 0000 and 0", out_valid, xfer_count);
        end
        checks++;
        if ({out_data3, out_data2, out_data1, out_data0} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL arst_data: got %h expected 0", {out_data3, out_data2, out_data1, out_data0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scenario sequence
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_data   = 32'h0;
        in_select = 2'd0;
        in_valid  = 1'b0;
        enable    = 1'b0;
        out_ready = 4'b0000;
        model_clear();

        test_reset();
        test_single_route();
        test_backpressure();
        test_independent();
        test_enable_high();
        test_counter_wrap();
        do_reset();
        test_random();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_2_select_buf.md
Name: demux_2_select_buf

Overview:
- Counterpart of the 2-bit-select multiplexer: routes one input data stream to one of four destinations, chosen by a 2-bit select.
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Used on the datapath wherever one producer writes a word to one of four consumers (e.g. writeback fan-out), where consumers may not accept in the same cycle.
- Enable is active-low, matching the multiplexer.

Parameters:
- DATA_WIDTH, 32, width of the data word on the input and on every output channel.
- CNT_WIDTH, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  word to route.
- in_select  input  2  destination channel: 0 -> channel 0 ... 3 -> channel 3.
- in_valid  input  1  producer has a word on in_data/in_select.
- in_ready  output  1  block accepts the word this cycle (combinational).
- enable  input  1  active-low; 0 = routing enabled, 1 = input stalled.
- out_data0 / out_data1 / out_data2 / out_data3  output  DATA_WIDTH each  channel holding-register contents.
- out_valid  output  4  bit i = channel i holds an unconsumed word.
- out_ready  input  4  bit i = consumer i takes the word this cycle.
- xfer_count  output  CNT_WIDTH  number of accepted input transfers, modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst_n = 0, asynchronous, any time including mid-transfer):
  - out_valid = 4'b0000.
  - out_data0..3 = 0.
  - xfer_count = 0.
  - All in-flight words are discarded.
  - in_ready = 0 while rst_n = 0.
- Per-channel state is EMPTY (valid_q[i] = 0) or FULL (valid_q[i] = 1). out_valid[i] = valid_q[i]; out_dataI = data_q[i].
- pop_i = valid_q[i] & out_ready[i].
- in_ready = (enable == 0) & (valid_q[in_select] == 0 | out_ready[in_select]). It depends only on the selected channel; other channels' fullness is ignored.
- accept = in_valid & in_ready. push_i = accept & (in_select == i).
- Channel update per clock edge:
  - push_i: data_q[i] <= in_data, valid_q[i] <= 1, EMPTY/FULL -> FULL. Push and pop in the same cycle is a pass-through refill; the channel stays FULL with the new word.
  - pop_i only: valid_q[i] <= 0, FULL -> EMPTY. data_q[i] retains its last value.
  - neither: hold.
- Latency: a word accepted at edge N appears on out_dataI with out_valid[i] = 1 after edge N; one cycle.
- Throughput: one word per cycle when consumers keep out_ready high.
- Simultaneous events: a pop on channel j and a push on channel k (j != k) in one cycle are independent and both take effect.
- enable = 1:
  - in_ready = 0 and no push occurs.
  - Pops continue, so channels still drain.
  - xfer_count holds.
  - enable is sampled combinationally with no registering.
- Producer obligations:
  - in_data and in_select must stay stable while in_valid = 1 and in_ready = 0.
  - The block does not check this.
- Consumer rules:
  - out_valid[i] never drops without a pop.
  - out_dataI never changes while out_valid[i] = 1 unless a pop occurs in the same cycle.
- xfer_count increments by 1 on every accept and wraps from all-ones to 0 with no flag.
- out_ready[i] asserted while channel i is EMPTY has no effect.
- Outputs are never tri-stated.

Test Plan:
- Reset then single route: in_select = 2, in_data = 32'hDEADBEEF, in_valid = 1 for one cycle, out_ready = 4'b0000 -> in_ready = 1; next cycle out_valid = 4'b0100, out_data2 = DEADBEEF, xfer_count = 1; other channels stay 0.
- Backpressure: channel 1 FULL, out_ready[1] = 0, new word to channel 1 -> in_ready = 0 and out_data1 unchanged. Then raise out_ready[1] -> same-cycle accept; the next word replaces it and out_valid[1] stays 1.
- Independent channels: channel 0 FULL and stalled; words to channels 1, 2, 3 on consecutive cycles -> all accepted, out_valid = 4'b1111, xfer_count += 3.
- Enable high: enable = 1, in_valid = 1 to channel 3 for 5 cycles, with channel 0 FULL and out_ready[0] = 1 -> in_ready = 0 throughout; channel 0 drains to out_valid[0] = 0; xfer_count unchanged.
- Counter wrap: CNT_WIDTH = 4, 17 accepts -> xfer_count = 1.
- Asynchronous reset mid-stream: assert rst_n = 0 between clock edges with out_valid = 4'b1011 -> out_valid = 0, all out_data = 0, xfer_count = 0 immediately, without waiting for clk.
